divider: RTL and testbench



---
 rtl/divider.sv | 110 +++++++++++
 tb/tb_divider.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential restoring shift-subtract divider: 32-bit dividend / 16-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_DBZ_EN: a zero divisor finishes on the load edge and raises dbz.
module divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        trig,
   input  logic [31:0] C_in,
   input  logic [15:0] B_in,
   output logic [31:0] Q_out,
   output logic [15:0] R_out,
   output logic        fin,
   output logic        dbz
);

   localparam int unsigned DW = 32;
   localparam int unsigned VW = 16;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e          state_q;
   logic [DW-1:0]   dvd_q;
   logic [VW-1:0]   div_q;
   logic [VW:0]     rem_q;
   logic [CW-1:0]   cnt_q;

   logic [VW:0]     rem_sh_c;
   logic [VW:0]     rem_nx_c;
   logic            qbit_c;

   // One restoring iteration; the dividend register doubles as the quotient shift register.
   always_comb begin
      rem_sh_c = {rem_q[VW-1:0], dvd_q[DW-1]};
      qbit_c   = (rem_sh_c >= {1'b0, div_q});
      rem_nx_c = qbit_c ? (rem_sh_c - {1'b0, div_q}) : rem_sh_c;
   end

`ifdef DIVIDER_DBZ_EN
   logic dbz_q;
   assign dbz = dbz_q;
`else
   assign dbz = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         Q_out   <= '0;
         R_out   <= '0;
         fin     <= 1'b0;
`ifdef DIVIDER_DBZ_EN
         dbz_q   <= 1'b0;
`endif
      end else if (!trig) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         Q_out   <= '0;
         R_out   <= '0;
         fin     <= 1'b0;
`ifdef DIVIDER_DBZ_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               dvd_q <= C_in;
               div_q <= B_in;
               rem_q <= '0;
               cnt_q <= '0;
`ifdef DIVIDER_DBZ_EN
               if (B_in == '0) begin
                  state_q <= DONE;
                  Q_out   <= '1;
                  R_out   <= C_in[VW-1:0];
                  dbz_q   <= 1'b1;
                  fin     <= 1'b1;
               end else begin
                  state_q <= BUSY;
               end
`else
               state_q <= BUSY;
`endif
            end
            BUSY: begin
               rem_q <= rem_nx_c;
               dvd_q <= {dvd_q[DW-2:0], qbit_c};
               cnt_q <= cnt_q + CW'(1);
               // Last iteration publishes the result on the same edge.
               if (cnt_q == CW'(DW - 1)) begin
                  Q_out   <= {dvd_q[DW-2:0], qbit_c};
                  R_out   <= rem_nx_c[VW-1:0];
                  fin     <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider; expected values are hand-computed constants.
module tb_divider;

   logic        clk;
   logic        rst;
   logic        trig;
   logic [31:0] C_in;
   logic [15:0] B_in;
   logic [31:0] Q_out;
   logic [15:0] R_out;
   logic        fin;
   logic        dbz;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   divider dut (
      .clk   (clk),
      .rst   (rst),
      .trig  (trig),
      .C_in  (C_in),
      .B_in  (B_in),
      .Q_out (Q_out),
      .R_out (R_out),
      .fin   (fin),
      .dbz   (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, ".fin"}, 64'(fin), 64'd0);
      check_val({tag, ".q"},   64'(Q_out), 64'd0);
      check_val({tag, ".r"},   64'(R_out), 64'd0);
      check_val({tag, ".dbz"}, 64'(dbz), 64'd0);
   endtask

   // Raise trig with operands, then check fin is low one edge early and the result lands exactly at lat edges.
   task automatic run_op(input string tag, input logic [31:0] c, input logic [15:0] b,
                         input int lat, input logic [31:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_dbz, input bit scramble);
      C_in = c;
      B_in = b;
      trig = 1'b1;
      repeat (lat - 1) begin
         @(posedge clk);
         #1;
         if (scramble) begin
            C_in = $urandom;
            B_in = 16'($urandom);
         end
      end
      check_val({tag, ".early_fin"}, 64'(fin), 64'd0);
      @(posedge clk);
      #1;
      check_val({tag, ".fin"}, 64'(fin), 64'd1);
      check_val({tag, ".q"},   64'(Q_out), 64'(exp_q));
      check_val({tag, ".r"},   64'(R_out), 64'(exp_r));
      check_val({tag, ".dbz"}, 64'(dbz), 64'(exp_dbz));
   endtask

   task automatic drop_trig(input string tag);
      trig = 1'b0;
      @(posedge clk);
      #1;
      check_zero(tag);
   endtask

   initial begin
      rst  = 1'b1;
      trig = 1'b0;
      C_in = '0;
      B_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      run_op("d100000_7", 32'd100000, 16'd7, 33, 32'd14285, 16'd5, 1'b0, 1'b0);
      // Holding trig keeps the result.
      repeat (3) @(posedge clk);
      #1;
      check_val("hold.fin", 64'(fin), 64'd1);
      check_val("hold.q", 64'(Q_out), 64'd14285);
      drop_trig("abort_done1");

      run_op("max", 32'hFFFF_FFFF, 16'hFFFF, 33, 32'h0001_0001, 16'd0, 1'b0, 1'b0);
      drop_trig("abort_done2");

      run_op("small_scr", 32'd5, 16'd9, 33, 32'd0, 16'd5, 1'b0, 1'b1);
      drop_trig("abort_done3");

      run_op("d1000_3_scr", 32'd1000, 16'd3, 33, 32'd333, 16'd1, 1'b0, 1'b1);
      drop_trig("abort_done4");

      // Abort at iteration 10, then a fresh operation.
      C_in = 32'd1000;
      B_in = 16'd3;
      trig = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check_val("abort_busy.fin", 64'(fin), 64'd0);
      drop_trig("abort_busy");
      run_op("d81_9", 32'd81, 16'd9, 33, 32'd9, 16'd0, 1'b0, 1'b0);
      drop_trig("abort_done5");

      // Reset at iteration 20 with trig held, then reload on first edge after release.
      C_in = 32'd1000;
      B_in = 16'd3;
      trig = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_zero("rst_busy");
      rst = 1'b0;
      run_op("after_rst", 32'd100, 16'd7, 33, 32'd14, 16'd2, 1'b0, 1'b0);
      drop_trig("abort_done6");

`ifdef DIVIDER_DBZ_EN
      run_op("dbz", 32'h1234_5678, 16'd0, 1, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0);
`else
      run_op("dbz", 32'h1234_5678, 16'd0, 33, 32'hFFFF_FFFF, 16'h5678, 1'b0, 1'b0);
`endif
      // Reset while DONE clears the held result.
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_zero("rst_done");
      rst  = 1'b0;
      trig = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
